// File: rtl/sensor_packet_scheduler.sv
// Round-robin arbiter that grants one sensor source at a time and frames its
// 24-byte sample into a 32-byte packet offered to the SPI slave.
module sensor_packet_scheduler #(
   parameter int         N_SRC         = 2,
   parameter int         PAYLOAD_BYTES = 24,
   parameter int         STALL_CYCLES  = 1000000,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [N_SRC-1:0]                src_valid,
   output logic [N_SRC-1:0]                src_ready,
   input  logic [N_SRC*PAYLOAD_BYTES*8-1:0] src_payload,
   output logic [7:0]                      data_bytes [0:31],
   output logic                            data_ready,
   input  logic                            data_ack,
   output logic [7:0]                      seq_num,
   output logic                            busy,
   output logic                            stall,
   output logic [7:0]                      stall_count
);

   localparam int PW = PAYLOAD_BYTES * 8;
   localparam int CW = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] STALL_LAST = CW'(STALL_CYCLES - 1);
   localparam logic [CW-1:0] STALL_MAX  = CW'(STALL_CYCLES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_BUILD = 2'd2;
   localparam logic [1:0] ST_OFFER = 2'd3;

   logic [1:0]    state;
   logic [1:0]    gnt_id;
   logic [1:0]    rr_ptr;
   logic [255:0]  pkt_vec;
   logic          last_stall;
   logic [CW-1:0] wait_cnt;

   logic          found;
   logic [1:0]    pick;
   logic [2:0]    cand;
   logic [2:0]    rr_next;
   logic [PW-1:0] payload_sel;
   logic [7:0]    csum;

   // First valid source at or after rr_ptr, wrapping modulo N_SRC.
   always_comb begin
      found = 1'b0;
      pick  = 2'd0;
      cand  = 3'd0;
      for (int i = 0; i < N_SRC; i++) begin
         cand = {1'b0, rr_ptr} + 3'(i);
         if (cand >= 3'(N_SRC)) begin
            cand = cand - 3'(N_SRC);
         end
         for (int k = 0; k < N_SRC; k++) begin
            if (!found && cand == 3'(k) && src_valid[k]) begin
               found = 1'b1;
               pick  = cand[1:0];
            end
         end
      end
   end

   always_comb begin
      src_ready   = '0;
      payload_sel = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (gnt_id == 2'(k)) begin
            src_ready[k] = (state == ST_GRANT);
            payload_sel  = src_payload[k*PW +: PW];
         end
      end
   end

   // Checksum covers the header about to be written plus the captured payload.
   always_comb begin
      csum = SYNC_BYTE ^ {6'b0, gnt_id} ^ seq_num ^ {7'b0, last_stall};
      for (int j = 0; j < PAYLOAD_BYTES; j++) begin
         csum = csum ^ pkt_vec[32 + 8*j +: 8];
      end
   end

   assign rr_next = {1'b0, gnt_id} + 3'd1;
   assign busy    = (state != ST_IDLE);

   for (genvar g = 0; g < 32; g++) begin : g_bytes
      assign data_bytes[g] = pkt_vec[255 - 8*g -: 8];
   end

   // Byte 3 reports whether the previous packet stalled, so the flag is kept
   // in last_stall when the ack clears stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         gnt_id      <= 2'd0;
         rr_ptr      <= 2'd0;
         pkt_vec     <= '0;
         data_ready  <= 1'b0;
         seq_num     <= 8'd0;
         stall       <= 1'b0;
         stall_count <= 8'd0;
         last_stall  <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && found) begin
                  gnt_id <= pick;
                  state  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               pkt_vec[32 +: PW] <= payload_sel;
               rr_ptr            <= (rr_next == 3'(N_SRC)) ? 2'd0 : rr_next[1:0];
               state             <= ST_BUILD;
            end
            ST_BUILD: begin
               pkt_vec[255:224] <= {SYNC_BYTE, 6'b0, gnt_id, seq_num, 7'b0, last_stall};
               pkt_vec[31:0]    <= {24'h0, csum};
               data_ready       <= 1'b1;
               wait_cnt         <= '0;
               state            <= ST_OFFER;
            end
            ST_OFFER: begin
               if (data_ack) begin
                  data_ready <= 1'b0;
                  stall      <= 1'b0;
                  last_stall <= stall;
                  wait_cnt   <= '0;
                  seq_num    <= seq_num + 8'd1;
                  state      <= ST_IDLE;
               end else begin
                  if (wait_cnt != STALL_MAX) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
                  if (wait_cnt == STALL_LAST && !stall) begin
                     stall <= 1'b1;
                     if (stall_count != 8'hFF) begin
                        stall_count <= stall_count + 8'd1;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
